branch_history_table: RTL and testbench

- Direct-mapped local-history table sitting directly upstream of the per-index pattern prediction tables.
- Lookup: combinationally supplies the 3-bit local history (prev_history) for the fetch pc.
- Resolve: runs a 2-stage pipeline that produces the eviction pulse, the pattern-table update strobe and the update address.
- Owns tag/valid/history state for 8 entries, indexed by pc[2:0] with tag pc[9:3].

---
 rtl/bht_pkg.sv | 44 ++++
 rtl/bht_forward_mux.sv | 33 +++
 rtl/branch_history_table.sv | 231 +++++++++++++++++++++++
 tb/tb_branch_history_table.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// -----------------------------------------------------------------------------
// bht_pkg
// Shared constants and types for the local branch history table.
//   ENTRY_WIDTH : log2 of the entry count; the index is pc[ENTRY_WIDTH-1:0]
//   PC_WIDTH    : program-counter width
//   HIST_WIDTH  : local history bits kept per entry
//   CNT_WIDTH   : width of the saturating eviction counter
// Types:
//   bht_entry_t     : one table entry (valid, tag, history)
//   resolve_req_t   : raw resolve request latched into S1
//   resolve_stage_t : S2 contents (request plus the history/hit found in S1)
// -----------------------------------------------------------------------------
package bht_pkg;

    localparam int ENTRY_WIDTH = 3;
    localparam int PC_WIDTH    = 10;
    localparam int HIST_WIDTH  = 3;
    localparam int CNT_WIDTH   = 16;
    localparam int NUM_ENTRIES = 1 << ENTRY_WIDTH;
    localparam int TAG_WIDTH   = PC_WIDTH - ENTRY_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [HIST_WIDTH-1:0] hist;
    } bht_entry_t;

    // S1 only holds the request; history and hit are produced during S1
    // and land in the S2 register.
    typedef struct packed {
        logic                valid;
        logic [PC_WIDTH-1:0] pc;
        logic                taken;
    } resolve_req_t;

    typedef struct packed {
        logic                  valid;
        logic [PC_WIDTH-1:0]   pc;
        logic                  taken;
        logic [HIST_WIDTH-1:0] hist;  // history before the shift (0 on a miss)
        logic                  hit;
    } resolve_stage_t;

endpackage

// File: rtl/bht_forward_mux.sv
// -----------------------------------------------------------------------------
// bht_forward_mux
// Picks the freshest view of one entry's history:
//   S2 pending write to the same index  -> S2's shifted history
//   else S1 allocating the same index   -> zero
//   else                                -> the stored history
// Ports:
//   i_stored_hist  : history currently held in the table
//   i_s2_match     : S2 is writing this index this cycle
//   i_s2_hist      : history S2 is about to write
//   i_alloc_match  : S1 is (re)allocating this index this cycle
//   o_hist         : forwarded history
// -----------------------------------------------------------------------------
module bht_forward_mux
    import bht_pkg::*;
(
    input  logic [HIST_WIDTH-1:0] i_stored_hist,
    input  logic                  i_s2_match,
    input  logic [HIST_WIDTH-1:0] i_s2_hist,
    input  logic                  i_alloc_match,
    output logic [HIST_WIDTH-1:0] o_hist
);

    always_comb begin
        o_hist = i_stored_hist;
        if (i_s2_match) begin
            o_hist = i_s2_hist;
        end else if (i_alloc_match) begin
            o_hist = '0;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// -----------------------------------------------------------------------------
// branch_history_table
// Direct-mapped local-history table feeding the per-index pattern tables.
// Lookup is combinational; resolves flow through a two-stage pipeline:
//   resolve sampled at edge k   -> S1 during the following cycle
//   S1 reads/allocates entry    -> evict visible after edge k+1
//   S2 shifts history at its end -> we/update_* visible after edge k+2
// so an eviction pulse always precedes the matching update by one cycle.
// Ports:
//   clk, rst (async, active low)
//   pc / lookup_hit / prev_history          : fetch-side lookup
//   resolve_valid / resolve_pc / resolve_taken : resolved branch
//   evict / evict_idx                        : reset request to pattern table
//   we / old_pc / branch_taken /
//   update_history / update_valid            : pattern-table update
//   evict_count                              : saturating eviction count
// -----------------------------------------------------------------------------
module branch_history_table
    import bht_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   lookup_hit,
    output logic [HIST_WIDTH-1:0]  prev_history,
    input  logic                   resolve_valid,
    input  logic [PC_WIDTH-1:0]    resolve_pc,
    input  logic                   resolve_taken,
    output logic                   evict,
    output logic [ENTRY_WIDTH-1:0] evict_idx,
    output logic                   we,
    output logic [PC_WIDTH-1:0]    old_pc,
    output logic                   branch_taken,
    output logic [HIST_WIDTH-1:0]  update_history,
    output logic                   update_valid,
    output logic [CNT_WIDTH-1:0]   evict_count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bht_entry_t     w_entry [NUM_ENTRIES];
    resolve_req_t   r_s1;
    resolve_stage_t r_s2;

    logic                   r_evict;
    logic [ENTRY_WIDTH-1:0] r_evict_idx;
    logic [CNT_WIDTH-1:0]   r_evict_count;
    logic                   r_we;
    logic [PC_WIDTH-1:0]    r_old_pc;
    logic                   r_branch_taken;
    logic [HIST_WIDTH-1:0]  r_update_history;
    logic                   r_update_valid;

    // ------------------------------------------------------------------
    // S2 write-side view
    // ------------------------------------------------------------------
    logic [ENTRY_WIDTH-1:0] w_s2_idx;
    logic [HIST_WIDTH-1:0]  w_s2_new_hist;

    assign w_s2_idx      = r_s2.pc[ENTRY_WIDTH-1:0];
    // Shift is computed from the history S1 captured, not from the table,
    // so a same-cycle allocate by a younger resolve cannot corrupt it.
    assign w_s2_new_hist = {r_s2.hist[HIST_WIDTH-2:0], r_s2.taken};

    // ------------------------------------------------------------------
    // S1: read entry with forwarding from S2
    // ------------------------------------------------------------------
    logic [ENTRY_WIDTH-1:0] w_s1_idx;
    logic [TAG_WIDTH-1:0]   w_s1_tag;
    bht_entry_t             w_s1_entry;
    logic                   w_s1_tag_hit;
    logic                   w_s1_alloc;
    logic                   w_s1_evict;
    logic                   w_s1_s2_match;
    logic [HIST_WIDTH-1:0]  w_s1_fwd_hist;
    logic [HIST_WIDTH-1:0]  w_s1_hist;
    bht_entry_t             w_alloc_entry;

    assign w_s1_idx   = r_s1.pc[ENTRY_WIDTH-1:0];
    assign w_s1_tag   = r_s1.pc[PC_WIDTH-1:ENTRY_WIDTH];
    assign w_s1_entry = w_entry[w_s1_idx];

    // Valid/tag need no forwarding: an older resolve's allocation has
    // already been committed by the time a younger one reaches S1.
    assign w_s1_tag_hit  = w_s1_entry.valid && (w_s1_entry.tag == w_s1_tag);
    assign w_s1_alloc    = r_s1.valid && !w_s1_tag_hit;
    assign w_s1_evict    = w_s1_alloc && w_s1_entry.valid;
    assign w_s1_s2_match = r_s2.valid && (w_s2_idx == w_s1_idx);

    bht_forward_mux u_s1_fwd (
        .i_stored_hist (w_s1_entry.hist),
        .i_s2_match    (w_s1_s2_match),
        .i_s2_hist     (w_s2_new_hist),
        .i_alloc_match (1'b0),
        .o_hist        (w_s1_fwd_hist)
    );

    // A fresh allocation starts from an empty history.
    assign w_s1_hist = w_s1_tag_hit ? w_s1_fwd_hist : '0;

    always_comb begin
        w_alloc_entry       = '0;
        w_alloc_entry.valid = 1'b1;
        w_alloc_entry.tag   = w_s1_tag;
    end

    // ------------------------------------------------------------------
    // Entry storage. Allocation beats the S2 history write on a
    // collision: S2 is older, so the younger allocate is the final state.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            bht_entry_t r_entry;
            logic       w_alloc_we;
            logic       w_hist_we;

            assign w_alloc_we = w_s1_alloc && (w_s1_idx == ENTRY_WIDTH'(gi));
            assign w_hist_we  = r_s2.valid && (w_s2_idx == ENTRY_WIDTH'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_entry <= '0;
                end else if (w_alloc_we) begin
                    r_entry <= w_alloc_entry;
                end else if (w_hist_we) begin
                    r_entry.hist <= w_s2_new_hist;
                end
            end

            assign w_entry[gi] = r_entry;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lookup (combinational)
    // ------------------------------------------------------------------
    logic [ENTRY_WIDTH-1:0] w_lk_idx;
    logic [TAG_WIDTH-1:0]   w_lk_tag;
    bht_entry_t             w_lk_entry;
    logic                   w_lk_s2_match;
    logic                   w_lk_alloc_match;

    assign w_lk_idx         = pc[ENTRY_WIDTH-1:0];
    assign w_lk_tag         = pc[PC_WIDTH-1:ENTRY_WIDTH];
    assign w_lk_entry       = w_entry[w_lk_idx];
    assign w_lk_s2_match    = r_s2.valid && (w_s2_idx == w_lk_idx);
    assign w_lk_alloc_match = w_s1_alloc && (w_s1_idx == w_lk_idx);

    assign lookup_hit = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

    bht_forward_mux u_lk_fwd (
        .i_stored_hist (w_lk_entry.hist),
        .i_s2_match    (w_lk_s2_match),
        .i_s2_hist     (w_s2_new_hist),
        .i_alloc_match (w_lk_alloc_match),
        .o_hist        (prev_history)
    );

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1.valid <= resolve_valid;
            r_s1.pc    <= resolve_pc;
            r_s1.taken <= resolve_taken;

            r_s2.valid <= r_s1.valid;
            r_s2.pc    <= r_s1.pc;
            r_s2.taken <= r_s1.taken;
            r_s2.hist  <= w_s1_hist;
            r_s2.hit   <= w_s1_tag_hit;
        end
    end

    // ------------------------------------------------------------------
    // Eviction outputs (end of S1)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evict       <= 1'b0;
            r_evict_idx   <= '0;
            r_evict_count <= '0;
        end else begin
            r_evict <= w_s1_evict;
            if (w_s1_evict) begin
                r_evict_idx <= w_s1_idx;
                if (r_evict_count != {CNT_WIDTH{1'b1}}) begin
                    r_evict_count <= r_evict_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern-table update outputs (end of S2). Payload holds between
    // pulses and is only meaningful while we is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we             <= 1'b0;
            r_old_pc         <= '0;
            r_branch_taken   <= 1'b0;
            r_update_history <= '0;
            r_update_valid   <= 1'b0;
        end else begin
            r_we <= r_s2.valid;
            if (r_s2.valid) begin
                r_old_pc         <= r_s2.pc;
                r_branch_taken   <= r_s2.taken;
                r_update_history <= r_s2.hist;
                r_update_valid   <= r_s2.hit;
            end
        end
    end

    assign evict          = r_evict;
    assign evict_idx      = r_evict_idx;
    assign evict_count    = r_evict_count;
    assign we             = r_we;
    assign old_pc         = r_old_pc;
    assign branch_taken   = r_branch_taken;
    assign update_history = r_update_history;
    assign update_valid   = r_update_valid;

endmodule

// File: tb/tb_branch_history_table.sv
// -----------------------------------------------------------------------------
// tb_branch_history_table
// Directed and random resolve/lookup traffic against a program-order model
// of the table. Each step is one clock: resolve presented at step k produces
// evict at step k+2 and the update pulse at step k+3.
// -----------------------------------------------------------------------------
module tb_branch_history_table;

    logic        clk;
    logic        rst;
    logic [9:0]  pc;
    logic        lookup_hit;
    logic [2:0]  prev_history;
    logic        resolve_valid;
    logic [9:0]  resolve_pc;
    logic        resolve_taken;
    logic        evict;
    logic [2:0]  evict_idx;
    logic        we;
    logic [9:0]  old_pc;
    logic        branch_taken;
    logic [2:0]  update_history;
    logic        update_valid;
    logic [15:0] evict_count;

    branch_history_table dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .lookup_hit     (lookup_hit),
        .prev_history   (prev_history),
        .resolve_valid  (resolve_valid),
        .resolve_pc     (resolve_pc),
        .resolve_taken  (resolve_taken),
        .evict          (evict),
        .evict_idx      (evict_idx),
        .we             (we),
        .old_pc         (old_pc),
        .branch_taken   (branch_taken),
        .update_history (update_history),
        .update_valid   (update_valid),
        .evict_count    (evict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Program-order model of the table contents.
    logic        mv [8];
    logic [6:0]  mt [8];
    logic [2:0]  mh [8];
    logic [15:0] m_cnt;

    // Resolves not yet applied to the model (p1 younger, p2 older).
    logic        p1_v, p2_v;
    logic [9:0]  p1_pc, p2_pc;
    logic        p1_t, p2_t;

    // Expected update pulse for the next step.
    logic        ew_v;
    logic [9:0]  ew_pc;
    logic        ew_t;
    logic [2:0]  ew_uh;
    logic        ew_uv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            mt[i] = '0;
            mh[i] = '0;
        end
        m_cnt = '0;
        p1_v  = 1'b0;
        p2_v  = 1'b0;
        p1_pc = '0;
        p2_pc = '0;
        p1_t  = 1'b0;
        p2_t  = 1'b0;
        ew_v  = 1'b0;
        ew_pc = '0;
        ew_t  = 1'b0;
        ew_uh = '0;
        ew_uv = 1'b0;
    endtask

    task automatic step(input logic v, input logic [9:0] rpc, input logic t, input logic [9:0] lpc);
        logic [2:0] i;
        logic       hit;
        logic       ev;
        logic [2:0] uh;
        logic       s2v;
        logic [2:0] s2i;
        logic [2:0] li;
        logic [2:0] eh;
        @(negedge clk);
        chk("we", we, ew_v);
        if (ew_v) begin
            chk("old_pc", old_pc, ew_pc);
            chk("branch_taken", branch_taken, ew_t);
            chk("update_history", update_history, ew_uh);
            chk("update_valid", update_valid, ew_uv);
        end
        // Apply the resolve two steps back to the model, in program order.
        ev   = 1'b0;
        i    = p2_pc[2:0];
        ew_v = p2_v;
        if (p2_v) begin
            hit = mv[i] && (mt[i] == p2_pc[9:3]);
            ev  = !hit && mv[i];
            uh  = hit ? mh[i] : 3'b000;
            mv[i] = 1'b1;
            mt[i] = p2_pc[9:3];
            mh[i] = {uh[1:0], p2_t};
            if (ev && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            ew_pc = p2_pc;
            ew_t  = p2_t;
            ew_uh = uh;
            ew_uv = hit;
        end
        chk("evict", evict, ev);
        if (ev) chk("evict_idx", evict_idx, i);
        chk("evict_count", evict_count, m_cnt);
        s2v   = p2_v;
        s2i   = p2_pc[2:0];
        p2_v  = p1_v;
        p2_pc = p1_pc;
        p2_t  = p1_t;
        p1_v  = v;
        p1_pc = rpc;
        p1_t  = t;
        resolve_valid = v;
        resolve_pc    = rpc;
        resolve_taken = t;
        pc            = lpc;
        #1;
        // Lookup sees every older resolve, plus a zeroed history when the
        // resolve one step back is allocating this index and no update to
        // the index is pending in the same cycle.
        li = lpc[2:0];
        eh = mh[li];
        if (p2_v && (p2_pc[2:0] == li) && !(mv[li] && (mt[li] == p2_pc[9:3]))
            && !(s2v && (s2i == li)))
            eh = 3'b000;
        chk("lookup_hit", lookup_hit, mv[li] && (mt[li] == lpc[9:3]));
        chk("prev_history", prev_history, eh);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        resolve_valid = 1'b0;
        #1;
        chk("rst_evict", evict, 1'b0);
        chk("rst_evict_idx", evict_idx, 3'd0);
        chk("rst_evict_count", evict_count, 16'd0);
        chk("rst_we", we, 1'b0);
        chk("rst_old_pc", old_pc, 10'd0);
        chk("rst_branch_taken", branch_taken, 1'b0);
        chk("rst_update_history", update_history, 3'd0);
        chk("rst_update_valid", update_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        pc            = '0;
        resolve_valid = 1'b0;
        resolve_pc    = '0;
        resolve_taken = 1'b0;
        model_clear();
        do_reset();

        // Cold miss on 0x00B, then three spaced taken resolves.
        step(1'b1, 10'h00B, 1'b1, 10'h00B);          // step 0
        repeat (3) step(1'b0, 10'h0, 1'b0, 10'h00B); // steps 1-3
        step(1'b1, 10'h00B, 1'b1, 10'h00B);          // step 4
        chk("cold_lookup_hit", lookup_hit, 1'b1);
        chk("cold_prev_history", prev_history, 3'b001);
        repeat (2) step(1'b0, 10'h0, 1'b0, 10'h00B); // steps 5-6
        step(1'b1, 10'h00B, 1'b1, 10'h00B);          // step 7
        repeat (2) step(1'b0, 10'h0, 1'b0, 10'h00B); // steps 8-9
        step(1'b1, 10'h00B, 1'b1, 10'h00B);          // step 10
        repeat (3) step(1'b0, 10'h0, 1'b0, 10'h00B); // steps 11-13

        // Conflict on index 3 with a different tag.
        step(1'b1, 10'h013, 1'b1, 10'h00B);          // step 14
        chk("trained_prev_history", prev_history, 3'b111);
        step(1'b0, 10'h0, 1'b0, 10'h00B);            // step 15
        step(1'b0, 10'h0, 1'b0, 10'h00B);            // step 16
        chk("conflict_evict", evict, 1'b1);
        chk("conflict_evict_idx", evict_idx, 3'd3);
        chk("conflict_evict_count", evict_count, 16'd1);
        step(1'b0, 10'h0, 1'b0, 10'h00B);            // step 17
        chk("conflict_we", we, 1'b1);
        chk("conflict_update_history", update_history, 3'b000);
        chk("conflict_update_valid", update_valid, 1'b0);

        // Back-to-back on index 3: taken, taken, not-taken.
        step(1'b1, 10'h00B, 1'b1, 10'h00B);          // step 18
        step(1'b1, 10'h00B, 1'b1, 10'h00B);          // step 19
        step(1'b1, 10'h00B, 1'b0, 10'h00B);          // step 20
        step(1'b0, 10'h0, 1'b0, 10'h00B);            // step 21
        step(1'b0, 10'h0, 1'b0, 10'h00B);            // step 22
        chk("fwd_prev_history", prev_history, 3'b110);
        step(1'b0, 10'h0, 1'b0, 10'h00B);            // step 23
        chk("b2b_we", we, 1'b1);
        chk("b2b_update_history", update_history, 3'b011);
        chk("b2b_branch_taken", branch_taken, 1'b0);

        // Reset with a resolve sitting in S1.
        step(1'b1, 10'h01B, 1'b1, 10'h00B);
        do_reset();
        repeat (4) step(1'b0, 10'h0, 1'b0, 10'h00B);
        chk("post_rst_lookup_hit", lookup_hit, 1'b0);
        chk("post_rst_prev_history", prev_history, 3'b000);
        chk("post_rst_evict_count", evict_count, 16'd0);

        // Random traffic over 8 indices and 4 tags.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) != 0),
                 10'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)),
                 10'($urandom_range(0, 31)));
        end
        repeat (4) step(1'b0, 10'h0, 1'b0, 10'($urandom_range(0, 31)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
